// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encodings and the default
// geometry of the unified memory seen by fetch, memory and decode.
package fetch_unit_pkg;

  localparam int DEF_MEM_WORDS = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 16;
  localparam int FETCH_CNT_W   = 16;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_RESP = 2'd2,
    FS_HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port, redirect input and decode handshake of the fetch stage.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                   MemRead;
  logic [ADDR_W-1:0]      ADDR;
  logic [DATA_W-1:0]      Mem_Data;
  logic                   Redirect;
  logic [ADDR_W-1:0]      Redirect_PC;
  logic [DATA_W-1:0]      Instr;
  logic [ADDR_W-1:0]      Instr_PC;
  logic                   Instr_valid;
  logic                   Instr_ready;
  logic [FETCH_CNT_W-1:0] Fetch_count;

  modport master (
    output MemRead, ADDR, Instr, Instr_PC, Instr_valid, Fetch_count,
    input  Mem_Data, Redirect, Redirect_PC, Instr_ready
  );

  modport slave (
    input  MemRead, ADDR, Instr, Instr_PC, Instr_valid, Fetch_count,
    output Mem_Data, Redirect, Redirect_PC, Instr_ready
  );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: word index into the memory, wraps modulo MEM_WORDS.
module pc_counter
  import fetch_unit_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int RESET_PC  = 0,
  parameter int IDX_W     = $clog2(DEF_MEM_WORDS)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [IDX_W-1:0] load_val,
  input  logic             inc,
  output logic [IDX_W-1:0] pc
);
  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_PC % MEM_WORDS);

  logic [IDX_W-1:0] pc_r;

  // Load beats increment; power-of-two depth makes the add wrap for free.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pc_r <= RST_IDX;
    end else if (load) begin
      pc_r <= load_val;
    end else if (inc) begin
      pc_r <= pc_r + IDX_W'(1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, one registered memory read per
// instruction, instruction register and valid/ready handshake to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int RESET_PC  = 0
) (
  input  logic         CLK,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);

  fetch_state_t           state_r;
  logic [DATA_W-1:0]      instr_r;
  logic [ADDR_W-1:0]      instr_pc_r;
  logic                   instr_valid_r;
  logic [FETCH_CNT_W-1:0] fetch_count_r;
  logic [IDX_W-1:0]       pc_s;
  logic                   pc_load_s;
  logic                   pc_inc_s;
  logic                   unused_rpc_hi_s;

  assign unused_rpc_hi_s = ^bus.Redirect_PC[ADDR_W-1:IDX_W];

  pc_counter #(
    .MEM_WORDS (MEM_WORDS),
    .RESET_PC  (RESET_PC),
    .IDX_W     (IDX_W)
  ) u_pc (
    .CLK      (CLK),
    .reset    (reset),
    .load     (pc_load_s),
    .load_val (bus.Redirect_PC[IDX_W-1:0]),
    .inc      (pc_inc_s),
    .pc       (pc_s)
  );

  // PC control: a redirect suppresses the post-capture increment.
  always_comb begin
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    if (bus.Redirect) begin
      pc_load_s = 1'b1;
    end else if (state_r == FS_RESP) begin
      pc_inc_s = 1'b1;
    end else begin
      pc_inc_s = 1'b0;
    end
  end

  // Fetch FSM, instruction register and accepted-instruction counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r       <= FS_IDLE;
      instr_r       <= '0;
      instr_pc_r    <= '0;
      instr_valid_r <= 1'b0;
      fetch_count_r <= '0;
    end else begin
      // A handshake in HOLD completes even when a redirect lands the same cycle.
      if ((state_r == FS_HOLD) && bus.Instr_ready) begin
        fetch_count_r <= fetch_count_r + 16'd1;
      end else begin
        fetch_count_r <= fetch_count_r;
      end

      if (bus.Redirect) begin
        state_r       <= FS_REQ;
        instr_valid_r <= 1'b0;
      end else begin
        case (state_r)
          FS_IDLE: state_r <= FS_REQ;
          FS_REQ:  state_r <= FS_RESP;
          FS_RESP: begin
            instr_r       <= bus.Mem_Data;
            instr_pc_r    <= ADDR_W'(pc_s);
            instr_valid_r <= 1'b1;
            state_r       <= FS_HOLD;
          end
          FS_HOLD: begin
            if (bus.Instr_ready) begin
              instr_valid_r <= 1'b0;
              state_r       <= FS_REQ;
            end else begin
              state_r <= FS_HOLD;
            end
          end
          default: begin
            instr_valid_r <= 1'b0;
            state_r       <= FS_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.MemRead     = (state_r == FS_REQ);
  assign bus.ADDR        = ADDR_W'(pc_s);
  assign bus.Instr       = instr_r;
  assign bus.Instr_PC    = instr_pc_r;
  assign bus.Instr_valid = instr_valid_r;
  assign bus.Fetch_count = fetch_count_r;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a cycle-level
// behavioural model of the fetch pipeline and a bench-side memory.
module tb_fetch_unit;
  logic CLK;
  logic reset;

  fetch_unit_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  fetch_unit #(
    .MEM_WORDS (16),
    .DATA_W    (16),
    .ADDR_W    (16),
    .RESET_PC  (0)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [16];
  int n_vec;
  int n_bad;
  bit chk_en;

  // Model state: pc, pipeline position, held instruction, accept count.
  int          m_pc;
  bit          m_start, m_issue, m_wait, m_valid;
  logic [15:0] m_instr;
  int          m_ipc;
  logic [15:0] m_cnt;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Registered memory read port; garbage when no read was issued.
  always @(posedge CLK) begin
    if (bus.MemRead) bus.Mem_Data <= mem[int'(bus.ADDR) % 16];
    else             bus.Mem_Data <= 16'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit acc;
    if (reset) begin
      m_pc = 0; m_start = 1'b1; m_issue = 1'b0; m_wait = 1'b0;
      m_valid = 1'b0; m_instr = 16'h0000; m_ipc = 0; m_cnt = 16'h0000;
    end else begin
      acc = m_valid && bus.Instr_ready;
      if (acc) m_cnt = m_cnt + 16'd1;
      if (bus.Redirect) begin
        m_pc = int'(bus.Redirect_PC) % 16;
        m_valid = 1'b0; m_issue = 1'b1; m_wait = 1'b0; m_start = 1'b0;
      end else if (m_start) begin
        m_start = 1'b0; m_issue = 1'b1;
      end else if (m_issue) begin
        m_issue = 1'b0; m_wait = 1'b1;
      end else if (m_wait) begin
        m_wait = 1'b0; m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
        m_pc = (m_pc + 1) % 16;
      end else if (acc) begin
        m_valid = 1'b0; m_issue = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      model_step();
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        chk("MemRead", 32'(bus.MemRead), 32'(m_issue));
        chk("ADDR", 32'(bus.ADDR), 32'(m_pc));
        chk("Instr_valid", 32'(bus.Instr_valid), 32'(m_valid));
        chk("Instr", 32'(bus.Instr), 32'(m_instr));
        chk("Instr_PC", 32'(bus.Instr_PC), 32'(m_ipc));
        chk("Fetch_count", 32'(bus.Fetch_count), 32'(m_cnt));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  // Leaves the bench at cycle 0 (first cycle with reset low).
  task automatic do_reset(input int fill);
    reset = 1'b1;
    bus.Redirect = 1'b0;
    tick();
    chk_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (fill == 0)      mem[i] = 16'h1000 + 16'(i);
      else if (fill == 1) mem[i] = (i == 0) ? 16'h27E7 : 16'hDEAD;
      else                mem[i] = 16'($urandom);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_bad = 0; chk_en = 1'b0;
    reset = 1'b1;
    bus.Redirect = 1'b0;
    bus.Redirect_PC = 16'h0000;
    bus.Instr_ready = 1'b1;

    // First fetch after reset.
    do_reset(1);
    at_neg();
    chk("rst_MemRead", 32'(bus.MemRead), 32'd0);
    chk("rst_Instr_valid", 32'(bus.Instr_valid), 32'd0);
    tick(); at_neg();
    chk("c1_MemRead", 32'(bus.MemRead), 32'd1);
    chk("c1_ADDR", 32'(bus.ADDR), 32'd0);
    tick(); tick(); at_neg();
    chk("c3_Instr", 32'(bus.Instr), 32'h27E7);
    chk("c3_Instr_PC", 32'(bus.Instr_PC), 32'd0);
    chk("c3_valid", 32'(bus.Instr_valid), 32'd1);
    tick(); at_neg();
    chk("c4_ADDR", 32'(bus.ADDR), 32'd1);
    chk("c4_count", 32'(bus.Fetch_count), 32'd1);

    // Sequential fetch through the wrap.
    do_reset(0);
    for (int i = 0; i < 51; i++) tick();
    at_neg();
    chk("wrap_Instr", 32'(bus.Instr), 32'h1000);
    chk("wrap_Instr_PC", 32'(bus.Instr_PC), 32'd0);
    tick(); at_neg();
    chk("wrap_count", 32'(bus.Fetch_count), 32'd17);

    // Back-pressure in HOLD.
    bus.Instr_ready = 1'b0;
    do_reset(0);
    tick(); tick(); tick();
    for (int k = 0; k < 6; k++) begin
      at_neg();
      chk("bp_MemRead", 32'(bus.MemRead), 32'd0);
      chk("bp_valid", 32'(bus.Instr_valid), 32'd1);
      chk("bp_Instr", 32'(bus.Instr), 32'h1000);
      chk("bp_count", 32'(bus.Fetch_count), 32'd0);
      if (k == 5) bus.Instr_ready = 1'b1;
      tick();
    end
    at_neg();
    chk("bp_rel_MemRead", 32'(bus.MemRead), 32'd1);
    chk("bp_rel_ADDR", 32'(bus.ADDR), 32'd1);

    // Redirect in RESP, then redirect together with accept in HOLD.
    do_reset(0);
    tick(); tick();
    bus.Redirect = 1'b1; bus.Redirect_PC = 16'h0009;
    tick();
    bus.Redirect = 1'b0;
    at_neg();
    chk("rd_ADDR", 32'(bus.ADDR), 32'd9);
    chk("rd_MemRead", 32'(bus.MemRead), 32'd1);
    chk("rd_valid", 32'(bus.Instr_valid), 32'd0);
    tick(); tick(); at_neg();
    chk("rd_Instr", 32'(bus.Instr), 32'h1009);
    chk("rd_Instr_PC", 32'(bus.Instr_PC), 32'd9);
    bus.Redirect = 1'b1; bus.Redirect_PC = 16'h0013;
    tick();
    bus.Redirect = 1'b0;
    at_neg();
    chk("rdh_ADDR", 32'(bus.ADDR), 32'd3);
    chk("rdh_count", 32'(bus.Fetch_count), 32'd1);
    chk("rdh_valid", 32'(bus.Instr_valid), 32'd0);

    // Reset asserted while holding a valid instruction.
    do_reset(0);
    for (int i = 0; i < 6; i++) tick();
    at_neg();
    chk("rh_valid", 32'(bus.Instr_valid), 32'd1);
    chk("rh_Instr", 32'(bus.Instr), 32'h1001);
    chk("rh_count", 32'(bus.Fetch_count), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    at_neg();
    chk("rh_post_valid", 32'(bus.Instr_valid), 32'd0);
    chk("rh_post_count", 32'(bus.Fetch_count), 32'd0);
    chk("rh_post_MemRead", 32'(bus.MemRead), 32'd0);
    tick(); at_neg();
    chk("rh_refetch_ADDR", 32'(bus.ADDR), 32'd0);
    chk("rh_refetch_MemRead", 32'(bus.MemRead), 32'd1);

    // Random back-pressure, redirects and occasional resets.
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      bus.Instr_ready = ($urandom_range(0, 3) != 0);
      bus.Redirect    = ($urandom_range(0, 9) == 0);
      bus.Redirect_PC = 16'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset(2);
      end else begin
        tick();
      end
    end
    bus.Redirect = 1'b0;
    tick(); at_neg();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
